// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcodes, flag bit positions,
// FSM state encoding and the flag-packing helper.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_SHL = 4'h2,
    OP_OR  = 4'h3,
    OP_AND = 4'h4,
    OP_XOR = 4'h5,
    OP_ROL = 4'h6,
    OP_EQ  = 4'h7,
    OP_GTU = 4'h8,
    OP_LTU = 4'h9,
    OP_SHR = 4'hA,
    OP_SAR = 4'hB,
    OP_ROR = 4'hC,
    OP_MUL = 4'hD,
    OP_LTS = 4'hE,
    OP_ILL = 4'hF
  } alu_op_e;

  localparam int FLAG_Z   = 0;
  localparam int FLAG_C   = 1;
  localparam int FLAG_V   = 2;
  localparam int FLAG_N   = 3;
  localparam int FLAG_ILL = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  function automatic logic [4:0] pack_flags(input logic ill, input logic n,
                                            input logic v, input logic c,
                                            input logic z);
    logic [4:0] f;
    f           = '0;
    f[FLAG_ILL] = ill;
    f[FLAG_N]   = n;
    f[FLAG_V]   = v;
    f[FLAG_C]   = c;
    f[FLAG_Z]   = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// W cycles per operation, done pulses for one cycle with the product held.
module alu_mul_iter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product_lo,
  output logic         product_hi_nz
);

  localparam int CW = $clog2(W) + 1;

  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      acc_d    = '0;
      mcand_d  = {{W{1'b0}}, a};
      mplier_d = b;
      cnt_d    = CW'(W);
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign product_lo    = acc_q[W-1:0];
  assign product_hi_nz = |acc_q[2*W-1:W];

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle ops land in the result register on the accepting
// edge; MUL runs through the iterative multiplier before reaching HOLD.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic [3:0]           command,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic [4:0]           flags,
  output logic [1:0]           dbg_state
);

  localparam int SHW = $clog2(BUS_WIDTH);
  localparam logic [BUS_WIDTH:0] ONE = 1;

  logic [1:0]           state_q, state_d;
  logic [BUS_WIDTH-1:0] out_q, out_d;
  logic [4:0]           flags_q, flags_d;

  logic                 accept, is_mul, mul_start;
  logic                 mul_busy, mul_done, mul_hi_nz;
  logic [BUS_WIDTH-1:0] mul_lo;
  logic [SHW-1:0]       shamt;
  logic [BUS_WIDTH:0]   sum_w, diff_w;
  logic [BUS_WIDTH-1:0] alu_res;
  logic                 alu_c, alu_v, alu_ill;
  logic [4:0]           alu_flags;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready is combinational so HOLD can hand off and accept in one cycle.
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (command == OP_MUL);
  assign mul_start = accept && is_mul && !mul_busy;
  assign shamt     = b[SHW-1:0];

  alu_mul_iter #(.W(BUS_WIDTH)) u_mul (
    .clk           (clk),
    .reset         (reset),
    .start         (mul_start),
    .a             (a),
    .b             (b),
    .busy          (mul_busy),
    .done          (mul_done),
    .product_lo    (mul_lo),
    .product_hi_nz (mul_hi_nz)
  );

  always_comb begin
    sum_w   = {1'b0, a} + {1'b0, b};
    diff_w  = {1'b0, a} + {1'b0, ~b} + ONE;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (alu_op_e'(command))
      OP_ADD: begin
        alu_res = sum_w[BUS_WIDTH-1:0];
        alu_c   = sum_w[BUS_WIDTH];
        alu_v   = (a[BUS_WIDTH-1] == b[BUS_WIDTH-1]) &&
                  (sum_w[BUS_WIDTH-1] != a[BUS_WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_w[BUS_WIDTH-1:0];
        alu_c   = diff_w[BUS_WIDTH];
        alu_v   = (a[BUS_WIDTH-1] != b[BUS_WIDTH-1]) &&
                  (diff_w[BUS_WIDTH-1] != a[BUS_WIDTH-1]);
      end
      OP_SHL: alu_res = a << shamt;
      OP_OR:  alu_res = a | b;
      OP_AND: alu_res = a & b;
      OP_XOR: alu_res = a ^ b;
      // A shift by the full width yields zero, so amount 0 falls out as a.
      OP_ROL: alu_res = (a << shamt) | (a >> (BUS_WIDTH - int'(shamt)));
      OP_ROR: alu_res = (a >> shamt) | (a << (BUS_WIDTH - int'(shamt)));
      OP_EQ:  alu_res = {{(BUS_WIDTH-1){1'b0}}, (a == b)};
      OP_GTU: alu_res = {{(BUS_WIDTH-1){1'b0}}, (a > b)};
      OP_LTU: alu_res = {{(BUS_WIDTH-1){1'b0}}, (a < b)};
      OP_LTS: alu_res = {{(BUS_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SHR: alu_res = a >> shamt;
      OP_SAR: alu_res = $signed(a) >>> shamt;
      OP_MUL: alu_res = '0;
      OP_ILL: alu_ill = 1'b1;
      default: alu_ill = 1'b1;
    endcase
    alu_flags = pack_flags(alu_ill, alu_res[BUS_WIDTH-1], alu_v, alu_c, ~|alu_res);
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          if (is_mul) begin
            state_d = ST_BUSY;
          end else begin
            state_d = ST_HOLD;
            out_d   = alu_res;
            flags_d = alu_flags;
          end
        end else if ((state_q == ST_HOLD) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          state_d = ST_HOLD;
          out_d   = mul_lo;
          flags_d = pack_flags(1'b0, mul_lo[BUS_WIDTH-1], 1'b0, mul_hi_nz, ~|mul_lo);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out       = out_q;
  assign flags     = flags_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu (BUS_WIDTH=16): directed vectors, MUL timing,
// back-to-back streaming, stall, mid-MUL reset and a random scoreboard run.
module tb_multicycle_alu;

  localparam int W = 16;
  localparam logic [3:0] C_ADD = 4'h0, C_SUB = 4'h1, C_SHL = 4'h2, C_XOR = 4'h5,
                         C_ROL = 4'h6, C_EQ = 4'h7, C_LTU = 4'h9, C_SAR = 4'hB,
                         C_ROR = 4'hC, C_MUL = 4'hD, C_LTS = 4'hE, C_ILL = 4'hF;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   command = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out;
  logic [4:0]   flags;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  multicycle_alu #(.BUS_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .command   (command),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags),
    .dbg_state (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_results = 0;
  logic [20:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: returns {flags, out} with flags = {ill, N, V, C, Z}.
  function automatic logic [20:0] model(input logic [3:0] cmd, input logic [15:0] x,
                                        input logic [15:0] y);
    logic [15:0] r;
    logic [16:0] s;
    logic [31:0] p;
    logic        c, v;
    int          t, amt;
    r = '0; s = '0; p = '0; c = 1'b0; v = 1'b0;
    amt = int'(y) % 16;
    case (cmd)
      4'h0: begin
        s = {1'b0, x} + {1'b0, y}; r = s[15:0]; c = s[16];
        t = int'($signed(x)) + int'($signed(y)); v = (t > 32767) || (t < -32768);
      end
      4'h1: begin
        s = {1'b0, x} + {1'b0, ~y} + 17'd1; r = s[15:0]; c = s[16];
        t = int'($signed(x)) - int'($signed(y)); v = (t > 32767) || (t < -32768);
      end
      4'h2: r = x << amt;
      4'h3: r = x | y;
      4'h4: r = x & y;
      4'h5: r = x ^ y;
      4'h6: begin r = x; repeat (amt) r = {r[14:0], r[15]}; end
      4'h7: r = (x == y) ? 16'd1 : 16'd0;
      4'h8: r = (x > y) ? 16'd1 : 16'd0;
      4'h9: r = (x < y) ? 16'd1 : 16'd0;
      4'hA: r = x >> amt;
      4'hB: begin r = x; repeat (amt) r = {r[15], r[15:1]}; end
      4'hC: begin r = x; repeat (amt) r = {r[0], r[15:1]}; end
      4'hD: begin p = {16'd0, x} * {16'd0, y}; r = p[15:0]; c = |p[31:16]; end
      4'hE: r = ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
      default: return {5'b10001, 16'h0000};
    endcase
    return {1'b0, r[15], v, c, (r == 16'h0000), r};
  endfunction

  // Scoreboard: pop on result handshake, push on request handshake.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        n_results++;
        if (exp_q.size() == 0) check_val("unexpected_result", exp_q.size(), 1);
        else check_val("result", {11'd0, flags, out}, {11'd0, exp_q.pop_front()});
      end
      if (in_valid && in_ready) exp_q.push_back(model(command, a, b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [15:0] x, input logic [15:0] y);
    logic acc;
    int   k;
    in_valid = 1'b1; command = cmd; a = x; b = y;
    acc = 1'b0; k = 0;
    while (!acc && k < 100) begin
      #1;
      acc = in_ready;
      tick();
      k++;
    end
    in_valid = 1'b0;
    if (!acc) check_val("issue_timeout", acc, 1);
  endtask

  task automatic directed(input string tag, input logic [3:0] cmd, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] e_out, input logic [4:0] e_flags);
    out_ready = 1'b1;
    issue(cmd, x, y);
    check_val({tag, "_valid"}, out_valid, 1);
    check_val({tag, "_out"}, out, e_out);
    check_val({tag, "_flags"}, flags, e_flags);
    tick();
  endtask

  logic [15:0] held_out;
  logic [4:0]  held_flags;
  logic        saw_ready, acc;
  int          lat, cnt, base, k, ops_left;

  initial begin
    // Reset state
    repeat (3) tick();
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out", out, 0);
    check_val("rst_flags", flags, 0);
    reset = 1'b1;
    #1;
    check_val("rst_in_ready", in_ready, 1);
    tick();

    directed("add_wrap", C_ADD, 16'hFFFF, 16'h0001, 16'h0000, 5'b00011);
    directed("sub_ovf",  C_SUB, 16'h8000, 16'h0001, 16'h7FFF, 5'b00110);
    directed("lts",      C_LTS, 16'h8000, 16'h0001, 16'h0001, 5'b00000);
    directed("ltu",      C_LTU, 16'h8000, 16'h0001, 16'h0000, 5'b00001);
    directed("rol17",    C_ROL, 16'h8001, 16'd17,   16'h0003, 5'b00000);
    directed("sar4",     C_SAR, 16'h8000, 16'd4,    16'hF800, 5'b01000);
    directed("shl16",    C_SHL, 16'h1234, 16'd16,   16'h1234, 5'b00000);
    directed("ror1",     C_ROR, 16'h0001, 16'd1,    16'h8000, 5'b01000);
    directed("eq",       C_EQ,  16'h0005, 16'h0005, 16'h0001, 5'b00000);
    directed("illegal",  C_ILL, 16'h1234, 16'h5678, 16'h0000, 5'b10001);

    // MUL timing; junk on the inputs while busy must be ignored
    out_ready = 1'b1;
    issue(C_MUL, 16'h0100, 16'h0100);
    in_valid = 1'b1; command = C_ADD; a = 16'h1111; b = 16'h2222;
    saw_ready = 1'b0; lat = 0;
    while (!out_valid && lat < 60) begin
      if (in_ready) saw_ready = 1'b1;
      if (lat == 10) in_valid = 1'b0;
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check_val("mul_latency", lat, 17);
    check_val("mul_busy_ready", saw_ready, 0);
    check_val("mul_out", out, 16'h0000);
    check_val("mul_flags", flags, 5'b00011);
    tick();

    // Back-to-back ADD stream, then stall with out_ready low
    base = n_results;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom_range(0, 65535)); b = 16'($urandom_range(0, 65535));
      command = C_ADD; in_valid = 1'b1;
      check_val("b2b_ready", in_ready, 1);
      tick();
      check_val("b2b_valid", out_valid, 1);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    held_out = out; held_flags = flags;
    in_valid = 1'b1; command = C_XOR; a = 16'hAAAA; b = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("stall_valid", out_valid, 1);
      check_val("stall_out", out, held_out);
      check_val("stall_flags", flags, held_flags);
      check_val("stall_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check_val("stall_release", out_valid, 0);
    check_val("b2b_count", n_results - base, 8);

    // Reset in the seventh cycle of a MUL
    directed("xor_pre", C_XOR, 16'h00F0, 16'h0F00, 16'h0FF0, 5'b00000);
    issue(C_MUL, 16'h00FF, 16'h0103);
    repeat (6) tick();
    reset = 1'b0;
    #1;
    check_val("mid_rst_valid", out_valid, 0);
    check_val("mid_rst_out", out, 0);
    check_val("mid_rst_flags", flags, 0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_val("post_rst_ready", in_ready, 1);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    check_val("post_rst_no_result", cnt, 0);

    // Random traffic with random backpressure
    ops_left = 60; k = 0;
    while ((ops_left > 0 || exp_q.size() > 0 || out_valid) && k < 4000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && ops_left > 0 && $urandom_range(0, 1) == 1) begin
        command = 4'($urandom_range(0, 15));
        a = 16'($urandom_range(0, 65535));
        b = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(0, 65535));
        in_valid = 1'b1;
      end
      #1;
      acc = in_valid && in_ready;
      tick();
      k++;
      if (acc) begin
        in_valid = 1'b0;
        ops_left--;
      end
    end
    out_ready = 1'b1;
    check_val("rand_ops_done", ops_left, 0);
    check_val("rand_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 16, operand/result width; legal values are powers of two, 8..64.
REQ-002 SHALL have port clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  operation accepted when in_valid && in_ready at a clk edge.
REQ-006 SHALL have ports a, b  input  BUS_WIDTH  operands.
REQ-007 SHALL have port command  input  4  opcode per REQ-011.
REQ-008 SHALL have port out_valid  output  1  result register holds an unconsumed result.
REQ-009 SHALL have port out_ready  input  1  consumer takes result when out_valid && out_ready at a clk edge.
REQ-010 SHALL have ports out (output, BUS_WIDTH, result) and flags (output, 5, {illegal, N, V, C, Z}).

Function
REQ-011 Opcodes SHALL be: 0 ADD, 1 SUB (a-b), 2 SHL, 3 OR, 4 AND, 5 XOR, 6 ROL, 7 EQ, 8 GTU, 9 LTU, A SHR, B SAR, C ROR, D MUL, E LTS, F illegal.
REQ-012 Shift/rotate amount SHALL be b modulo BUS_WIDTH; amount 0 returns a unchanged.
REQ-013 ADD/SUB: C = carry-out (SUB: C=1 means no borrow); V = signed two's-complement overflow. For all other ops, C=0 and V=0, except MUL.
REQ-014 Compare ops SHALL return out = zero-extended 1-bit result.
REQ-015 MUL SHALL return the low BUS_WIDTH bits of unsigned a*b. C SHALL be 1 iff the high half is non-zero.
REQ-016 Z SHALL be (out==0). N SHALL be out[BUS_WIDTH-1]. These apply to every op.
REQ-017 Opcode F SHALL return out=0 and flags=5'b10001.
REQ-018 FSM SHALL have states IDLE, BUSY and HOLD.
  - IDLE: out_valid=0.
  - BUSY: MUL iterating.
  - HOLD: out_valid=1.
REQ-019 in_ready SHALL be (state==IDLE) || (state==HOLD && out_ready), combinationally.
REQ-020 Accepting a non-MUL op SHALL produce a registered result with out_valid=1 at the next edge (latency 1), entering HOLD.
REQ-021 Accepting MUL SHALL enter BUSY. It SHALL then perform one shift-add step per cycle for BUS_WIDTH cycles. It SHALL enter HOLD with result at edge BUS_WIDTH+1 after acceptance.
REQ-022 Operands and command SHALL be captured at acceptance; later input changes SHALL NOT affect the in-flight result.
REQ-023 HOLD with out_ready=0 SHALL hold out/flags/out_valid stable indefinitely.
REQ-024 HOLD handling:
  - If out_ready=1 and a new op is accepted in the same cycle, the new op SHALL proceed (back-to-back, throughput 1 op/cycle for non-MUL).
  - If out_ready=1 and no new op is accepted, the next state SHALL be IDLE.
REQ-025 in_ready SHALL be 0 throughout BUSY; in_valid during BUSY SHALL be ignored.

Reset
REQ-026 Asserting reset (low) SHALL immediately force state=IDLE, out=0, flags=0, out_valid=0, multiplier counter=0, regardless of the clk phase.
REQ-027 Reset during BUSY or HOLD SHALL discard the in-flight/unconsumed result. No result SHALL appear after deassertion.
REQ-028 in_ready SHALL be 1 in the first cycle after reset deassertion.

Structure
REQ-029 The opcode enumeration, flag bit indices and FSM state encoding SHALL live in shared package alu_pkg.
REQ-030 The iterative multiplier SHALL be a sub-module alu_mul_iter with ports start, a, b, busy, done, product_lo and product_hi_nz. The remaining datapath SHALL be inline.

Verification (BUS_WIDTH=16)
REQ-031 ADD 0xFFFF+0x0001 -> out=0x0000, flags Z=1, C=1, V=0, one cycle after accept.
REQ-032 SUB 0x8000-0x0001 -> out=0x7FFF, V=1, C=1. LTS 0x8000,0x0001 -> out=1. LTU 0x8000,0x0001 -> out=0.
REQ-033 ROL a=0x8001 b=17 -> out=0x0003. SAR a=0x8000 b=4 -> out=0xF800.
REQ-034 MUL 0x0100*0x0100 -> out=0x0000, C=1, Z=1, out_valid at edge 17 after accept. in_ready=0 for edges 1..16.
REQ-035 Back-to-back stream of 8 ADDs with out_ready held high -> 8 results on 8 consecutive cycles. Then out_ready=0 for 5 cycles -> out held stable and in_ready=0.
REQ-036 Reset pulse mid-MUL (cycle 7) -> out_valid=0 and out=0 immediately. No result emerges afterwards. in_ready=1 in the first cycle after deassertion.
